control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/opcode_decoder.sv | 35 +++
 rtl/control_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU control path:
//   - state_t       : control sequencer state enumeration
//   - OP_*          : 5-bit ALU / instruction opcodes
//   - IR_*_MSB/LSB  : bit positions of the instruction register fields
//   - ir_* helpers  : field extraction from a 32-bit instruction word
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_T0      = 4'd1,
        ST_T1      = 4'd2,
        ST_T2      = 4'd3,
        ST_T3      = 4'd4,
        ST_T4      = 4'd5,
        ST_T5      = 4'd6,
        ST_T6      = 4'd7,
        ST_ILLEGAL = 4'd8
    } state_t;

    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;

    localparam int IR_OPCODE_MSB = 31;
    localparam int IR_OPCODE_LSB = 27;
    localparam int IR_RA_MSB     = 26;
    localparam int IR_RA_LSB     = 23;
    localparam int IR_RB_MSB     = 22;
    localparam int IR_RB_LSB     = 19;
    localparam int IR_RC_MSB     = 18;
    localparam int IR_RC_LSB     = 15;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[IR_OPCODE_MSB:IR_OPCODE_LSB];
    endfunction

    function automatic logic [3:0] ir_ra(input logic [31:0] ir);
        return ir[IR_RA_MSB:IR_RA_LSB];
    endfunction

    function automatic logic [3:0] ir_rb(input logic [31:0] ir);
        return ir[IR_RB_MSB:IR_RB_LSB];
    endfunction

    function automatic logic [3:0] ir_rc(input logic [31:0] ir);
        return ir[IR_RC_MSB:IR_RC_LSB];
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// ---------------------------------------------------------------------------
// opcode_decoder
// Combinational classification of a 5-bit opcode.
// Ports:
//   opcode     in  [4:0]  instruction opcode
//   is_alu3    out        three-register ALU instruction
//   is_muldiv  out        MUL/DIV (only when CONTROL_SEQUENCER_MULDIV_EN is set)
//   is_illegal out        anything the sequencer cannot execute
// Configuration macro: CONTROL_SEQUENCER_MULDIV_EN
// ---------------------------------------------------------------------------
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       is_alu3,
    output logic       is_muldiv,
    output logic       is_illegal
);

    always_comb begin
        is_alu3   = 1'b0;
        is_muldiv = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: is_alu3 = 1'b1;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
            OP_MUL, OP_DIV:                  is_muldiv = 1'b1;
`endif
            default: ;
        endcase
        // Without MUL/DIV support those opcodes fall through to illegal.
        is_illegal = ~(is_alu3 | is_muldiv);
    end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Multi-cycle control unit: fetch (T0..T2) then execute (T3..T5/T6) one
// instruction per start request. Outputs are decoded from the registered
// state only (plus IR_Data, which is stable from T3 on).
// Ports:
//   clk, reset_n (sync, active-low), start, IR_Data[31:0]
//   bus selects : PC_select, Z_LO_select, Z_HI_select, MDR_select,
//                 rb_select, rc_select
//   loads       : PC_enable, PC_increment_enable, IR_enable, MAR_enable,
//                 MDR_enable, Y_enable, Z_enable, read
//   writes      : ra_enable, hi_enable, lo_enable
//   indices     : ra_idx, rb_idx, rc_idx [3:0]; alu_instruction [4:0]
//   status      : busy, done, illegal
// Configuration macro: CONTROL_SEQUENCER_MULDIV_EN (enables MUL/DIV and T6;
// otherwise MUL/DIV are illegal and hi_enable stays 0).
// ---------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] IR_Data,
    output logic        PC_select,
    output logic        Z_LO_select,
    output logic        Z_HI_select,
    output logic        MDR_select,
    output logic        rb_select,
    output logic        rc_select,
    output logic        PC_enable,
    output logic        PC_increment_enable,
    output logic        IR_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        read,
    output logic        ra_enable,
    output logic        hi_enable,
    output logic        lo_enable,
    output logic [3:0]  ra_idx,
    output logic [3:0]  rb_idx,
    output logic [3:0]  rc_idx,
    output logic [4:0]  alu_instruction,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_t     state_reg;
    state_t     state_next;

    logic [4:0] opcode;
    logic [3:0] ra_field;
    logic [3:0] rb_field;
    logic [3:0] rc_field;
    logic       is_alu3;
    logic       is_muldiv;
    logic       is_illegal;
    logic       unused_ir_bits;

    assign opcode         = ir_opcode(IR_Data);
    assign ra_field       = ir_ra(IR_Data);
    assign rb_field       = ir_rb(IR_Data);
    assign rc_field       = ir_rc(IR_Data);
    assign unused_ir_bits = ^IR_Data[14:0];

    opcode_decoder u_opcode_decoder (
        .opcode     (opcode),
        .is_alu3    (is_alu3),
        .is_muldiv  (is_muldiv),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        PC_select           = 1'b0;
        Z_LO_select         = 1'b0;
        Z_HI_select         = 1'b0;
        MDR_select          = 1'b0;
        rb_select           = 1'b0;
        rc_select           = 1'b0;
        PC_enable           = 1'b0;
        PC_increment_enable = 1'b0;
        IR_enable           = 1'b0;
        MAR_enable          = 1'b0;
        MDR_enable          = 1'b0;
        Y_enable            = 1'b0;
        Z_enable            = 1'b0;
        read                = 1'b0;
        ra_enable           = 1'b0;
        hi_enable           = 1'b0;
        lo_enable           = 1'b0;
        ra_idx              = ra_field;
        rb_idx              = rb_field;
        rc_idx              = rc_field;
        alu_instruction     = OP_NONE;
        busy                = 1'b1;
        done                = 1'b0;
        illegal             = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_T0;
                end
            end
            ST_T0: begin
                PC_select           = 1'b1;
                MAR_enable          = 1'b1;
                PC_increment_enable = 1'b1;
                Z_enable            = 1'b1;
                state_next          = ST_T1;
            end
            ST_T1: begin
                Z_LO_select = 1'b1;
                PC_enable   = 1'b1;
                read        = 1'b1;
                MDR_enable  = 1'b1;
                state_next  = ST_T2;
            end
            ST_T2: begin
                MDR_select = 1'b1;
                IR_enable  = 1'b1;
                state_next = ST_T3;
            end
            ST_T3: begin
                // Illegal opcodes spend T3 with nothing asserted.
                state_next = is_illegal ? ST_ILLEGAL : ST_T4;
                if (is_alu3 || is_muldiv) begin
                    rb_select = 1'b1;
                    Y_enable  = 1'b1;
                end
                // MUL/DIV take the ra register as the first operand.
                if (is_muldiv) begin
                    rb_idx = ra_field;
                end
            end
            ST_T4: begin
                rc_select       = 1'b1;
                Z_enable        = 1'b1;
                alu_instruction = opcode;
                if (is_muldiv) begin
                    rc_idx = rb_field;
                end
                state_next = ST_T5;
            end
            ST_T5: begin
                Z_LO_select = 1'b1;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
                if (is_muldiv) begin
                    lo_enable  = 1'b1;
                    state_next = ST_T6;
                end else begin
                    ra_enable  = 1'b1;
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
`else
                ra_enable  = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
`endif
            end
`ifdef CONTROL_SEQUENCER_MULDIV_EN
            ST_T6: begin
                Z_HI_select = 1'b1;
                hi_enable   = 1'b1;
                done        = 1'b1;
                state_next  = ST_IDLE;
            end
`endif
            ST_ILLEGAL: begin
                illegal    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench for control_sequencer. Expected per-cycle output
// vectors come from a table-style model: a fixed fetch prologue followed by
// an execute tail chosen from the opcode class. Honours
// CONTROL_SEQUENCER_MULDIV_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

`ifdef CONTROL_SEQUENCER_MULDIV_EN
    localparam bit MULDIV_SUPPORTED = 1'b1;
`else
    localparam bit MULDIV_SUPPORTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] IR_Data;
    logic PC_select, Z_LO_select, Z_HI_select, MDR_select, rb_select, rc_select;
    logic PC_enable, PC_increment_enable, IR_enable, MAR_enable, MDR_enable;
    logic Y_enable, Z_enable, read, ra_enable, hi_enable, lo_enable;
    logic [3:0] ra_idx, rb_idx, rc_idx;
    logic [4:0] alu_instruction;
    logic busy, done, illegal;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .IR_Data             (IR_Data),
        .PC_select           (PC_select),
        .Z_LO_select         (Z_LO_select),
        .Z_HI_select         (Z_HI_select),
        .MDR_select          (MDR_select),
        .rb_select           (rb_select),
        .rc_select           (rc_select),
        .PC_enable           (PC_enable),
        .PC_increment_enable (PC_increment_enable),
        .IR_enable           (IR_enable),
        .MAR_enable          (MAR_enable),
        .MDR_enable          (MDR_enable),
        .Y_enable            (Y_enable),
        .Z_enable            (Z_enable),
        .read                (read),
        .ra_enable           (ra_enable),
        .hi_enable           (hi_enable),
        .lo_enable           (lo_enable),
        .ra_idx              (ra_idx),
        .rb_idx              (rb_idx),
        .rc_idx              (rc_idx),
        .alu_instruction     (alu_instruction),
        .busy                (busy),
        .done                (done),
        .illegal             (illegal)
    );

    typedef struct packed {
        logic       pc_sel, zlo_sel, zhi_sel, mdr_sel, rb_sel, rc_sel;
        logic       pc_en, pc_inc, ir_en, mar_en, mdr_en, y_en, z_en, rd;
        logic       ra_en, hi_en, lo_en;
        logic [3:0] ra_i, rb_i, rc_i;
        logic [4:0] alu;
        logic       busy, done, ill;
    } ov_t;

    ov_t obs;
    assign obs = {PC_select, Z_LO_select, Z_HI_select, MDR_select, rb_select, rc_select,
                  PC_enable, PC_increment_enable, IR_enable, MAR_enable, MDR_enable,
                  Y_enable, Z_enable, read, ra_enable, hi_enable, lo_enable,
                  ra_idx, rb_idx, rc_idx, alu_instruction, busy, done, illegal};

    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_txn = 0;
    ov_t exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ov_t idle_ov(input logic [31:0] ir);
        ov_t o = '0;
        o.ra_i = ir[26:23];
        o.rb_i = ir[22:19];
        o.rc_i = ir[18:15];
        return o;
    endfunction

    // Build the expected cycle-by-cycle outputs from T0 until the last
    // busy cycle of one instruction.
    task automatic build_exp(input logic [31:0] ir);
        ov_t b, s;
        int  op;
        bit  alu3, md;
        op   = int'(ir[31:27]);
        alu3 = (op >= 3) && (op <= 11);
        md   = MULDIV_SUPPORTED && (op == 15 || op == 16);
        b = idle_ov(ir);
        b.busy = 1'b1;
        exp_q.delete();
        s = b; s.pc_sel = 1; s.mar_en = 1; s.pc_inc = 1; s.z_en = 1; exp_q.push_back(s);
        s = b; s.zlo_sel = 1; s.pc_en = 1; s.rd = 1; s.mdr_en = 1;   exp_q.push_back(s);
        s = b; s.mdr_sel = 1; s.ir_en = 1;                           exp_q.push_back(s);
        if (alu3) begin
            s = b; s.rb_sel = 1; s.y_en = 1;                             exp_q.push_back(s);
            s = b; s.rc_sel = 1; s.z_en = 1; s.alu = ir[31:27];          exp_q.push_back(s);
            s = b; s.zlo_sel = 1; s.ra_en = 1; s.done = 1;               exp_q.push_back(s);
        end else if (md) begin
            s = b; s.rb_sel = 1; s.y_en = 1; s.rb_i = ir[26:23];         exp_q.push_back(s);
            s = b; s.rc_sel = 1; s.z_en = 1; s.alu = ir[31:27];
            s.rc_i = ir[22:19];                                          exp_q.push_back(s);
            s = b; s.zlo_sel = 1; s.lo_en = 1;                           exp_q.push_back(s);
            s = b; s.zhi_sel = 1; s.hi_en = 1; s.done = 1;               exp_q.push_back(s);
        end else begin
            s = b;                                                       exp_q.push_back(s);
            s = b; s.ill = 1;                                            exp_q.push_back(s);
        end
    endtask

    task automatic check_cycle(input string tag, input ov_t exp);
        check_val(tag, obs, exp);
        check_val("one_sel", ($countones({PC_select, Z_LO_select, Z_HI_select,
                                          MDR_select, rb_select, rc_select}) <= 1), 1);
    endtask

    // Called just after a rising edge with the DUT in IDLE. Checks the IDLE
    // cycle, then every cycle of the instruction.
    task automatic run_instr(input logic [31:0] ir, input bit hold);
        IR_Data = ir;
        start   = 1'b1;
        build_exp(ir);
        @(negedge clk);
        check_cycle("idle", idle_ov(ir));
        @(posedge clk); #1;
        start = hold;
        foreach (exp_q[i]) begin
            @(negedge clk);
            check_cycle($sformatf("op%05b_step%0d", ir[31:27], i), exp_q[i]);
            @(posedge clk); #1;
        end
        n_txn++;
        $display("txn %0d ir=%h op=%05b cycles=%0d hold=%0d", n_txn, ir, ir[31:27], exp_q.size(), hold);
    endtask

    // Start an ALU instruction and pull reset while it is in T4.
    task automatic run_reset_t4(input logic [31:0] ir);
        IR_Data = ir;
        start   = 1'b1;
        build_exp(ir);
        @(negedge clk);
        check_cycle("idle", idle_ov(ir));
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) reset_n = 1'b0;
            @(negedge clk);
            check_cycle($sformatf("rst_step%0d", i), exp_q[i]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_cycle("after_rst", idle_ov(ir));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_cycle("rst_wait", idle_ov(ir));
        @(posedge clk); #1;
        n_txn++;
        $display("txn %0d ir=%h reset during T4", n_txn, ir);
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] op;
        case ($urandom_range(0, 3))
            0, 1:    op = 5'($urandom_range(3, 11));
            2:       op = ($urandom_range(0, 1) == 0) ? 5'b01111 : 5'b10000;
            default: op = 5'($urandom_range(0, 31));
        endcase
        return {op, 27'($urandom)};
    endfunction

    initial begin
        logic [31:0] ir;
        reset_n = 1'b0;
        start   = 1'b1;
        IR_Data = 32'h409A8000;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_cycle("reset", idle_ov(IR_Data));
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        check_cycle("post_reset", idle_ov(IR_Data));
        @(posedge clk); #1;

        run_instr(32'h409A8000, 1'b0);                         // SHRA R1,R3,R5
        run_instr(32'h18A00000, 1'b0);                         // ADD R1,R2,R0
        run_instr({5'b01111, 4'd2, 4'd6, 4'd9, 15'h0}, 1'b0);  // MUL
        run_instr({5'b10000, 4'd7, 4'd1, 4'd3, 15'h0}, 1'b0);  // DIV
        run_instr({5'b11111, 4'd4, 4'd5, 4'd6, 15'h0}, 1'b0);  // illegal
        run_instr({5'b00000, 4'd1, 4'd1, 4'd1, 15'h0}, 1'b0);  // illegal
        run_reset_t4(32'h18A00000);
        run_instr(32'h18A00000, 1'b0);

        // start held high: one IDLE cycle between consecutive instructions
        for (int i = 0; i < 8; i++) begin
            run_instr(rand_ir(), 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            ir = rand_ir();
            run_instr(ir, 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(negedge clk);
                check_cycle("gap", idle_ov(ir));
                @(posedge clk); #1;
            end
        end

        @(negedge clk);
        check_cycle("final_idle", idle_ov(IR_Data));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
